// File: rtl/clk_divider_multi.sv
// clk_divider_multi: NUM_CH independent programmable dividers of clk_in with glitch-free divisor updates.
// Latency: clk_out/tick are registered and lag each channel's phase counter by one clk_in cycle.
// Backpressure: cfg_ready drops while the addressed channel still holds an unapplied divisor.

// Per-channel divider: phase counter, active/next divisor pair and registered outputs.
module clk_divider_multi_ch #(
    parameter int              DIV_W   = 16,
    parameter logic [DIV_W-1:0] DEF_DIV = 16'd5000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_acc,
    input  logic [DIV_W-1:0] i_acc_div,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_pending
);

    // A reset divisor below 2 cannot form a high and a low phase, so it is raised to 2.
    localparam logic [DIV_W-1:0] DEF_CLAMPED = (DEF_DIV < DIV_W'(2)) ? DIV_W'(2) : DEF_DIV;

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_nxt_div;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_tick;

    logic             w_last;
    logic             w_apply;
    logic [DIV_W-1:0] w_half;

    // Last cycle of the current period; r_cnt never exceeds r_div-1 so this always fires.
    assign w_last  = (r_cnt == (r_div - DIV_W'(1)));
    // A waiting divisor is swapped in at a period boundary, or at once while the channel is idle.
    assign w_apply = r_pending & (~i_en | w_last);
    assign w_half  = r_div >> 1;

    // Phase counter: wraps at the period end, restarts on disable or on a divisor swap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_apply || !i_en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    // Active divisor: only changes at the boundary so the running period completes unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= DEF_CLAMPED;
        end else if (w_apply) begin
            r_div <= r_nxt_div;
        end
    end

    // Staged divisor captured from an accepted config request (already clamped upstream).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_nxt_div <= DEF_CLAMPED;
        end else if (i_acc) begin
            r_nxt_div <= i_acc_div;
        end
    end

    // Pending flag: set on accept, cleared on apply; accept wins since ready blocks a same-edge clash.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= 1'b0;
        end else if (i_acc) begin
            r_pending <= 1'b1;
        end else if (w_apply) begin
            r_pending <= 1'b0;
        end
    end

    // Registered outputs: high for the first floor(div/2) phases, tick on the final phase.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_clk_out <= (r_cnt < w_half);
            r_tick    <= w_last;
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_pending = r_pending;

endmodule

module clk_divider_multi #(
    parameter int                      NUM_CH      = 2,
    parameter int                      DIV_W       = 16,
    parameter logic [NUM_CH*DIV_W-1:0] DEFAULT_DIV = {16'd50000, 16'd5000},
    localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [DIV_W-1:0]  i_cfg_div,
    output logic [NUM_CH-1:0] o_cfg_pending,
    output logic [NUM_CH-1:0] o_clk_out,
    output logic [NUM_CH-1:0] o_tick
);

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_acc;
    logic              w_sel_pending;
    logic [DIV_W-1:0]  w_cfg_div_clamped;

    // Pending flag of the addressed channel; an out-of-range channel matches nothing and reads 0,
    // so such requests are always ready and silently dropped.
    always_comb begin
        w_sel_pending = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_cfg_ch == CH_W'(i)) begin
                w_sel_pending = w_pending[i];
            end
        end
    end

    assign o_cfg_ready       = ~w_sel_pending;
    assign w_cfg_div_clamped = (i_cfg_div < DIV_W'(2)) ? DIV_W'(2) : i_cfg_div;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_acc[g] = i_cfg_valid & o_cfg_ready & (i_cfg_ch == CH_W'(g));

        clk_divider_multi_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEFAULT_DIV[g*DIV_W +: DIV_W])
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_en      (i_ch_en[g]),
            .i_acc     (w_acc[g]),
            .i_acc_div (w_cfg_div_clamped),
            .o_clk_out (o_clk_out[g]),
            .o_tick    (o_tick[g]),
            .o_pending (w_pending[g])
        );
    end

    assign o_cfg_pending = w_pending;

endmodule

// File: tb/tb_clk_divider_multi.sv
module tb_clk_divider_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_pending;
    logic [1:0]  clk_out;
    logic [1:0]  tick;

    logic        b_rst;
    logic [2:0]  b_en;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_ch;
    logic [7:0]  b_div;
    logic [2:0]  b_pend;
    logic [2:0]  b_clk;
    logic [2:0]  b_tick;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_divider_multi dut (
        .i_clk(clk), .i_rst(rst), .i_ch_en(ch_en), .i_cfg_valid(cfg_valid),
        .o_cfg_ready(cfg_ready), .i_cfg_ch(cfg_ch), .i_cfg_div(cfg_div),
        .o_cfg_pending(cfg_pending), .o_clk_out(clk_out), .o_tick(tick)
    );

    clk_divider_multi #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV({8'd7, 8'd1, 8'd0})) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_ch_en(b_en), .i_cfg_valid(b_valid),
        .o_cfg_ready(b_ready), .i_cfg_ch(b_ch), .i_cfg_div(b_div),
        .o_cfg_pending(b_pend), .o_clk_out(b_clk), .o_tick(b_tick)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: position within the current period, the period length in use,
    // and a staged divisor that replaces it once the period in progress is over.
    int       def_div[2] = '{5000, 50000};
    int       m_pos[2];
    int       m_per[2];
    int       m_stage[2];
    bit [1:0] m_pend;
    bit [1:0] m_clk;
    bit [1:0] m_tick;

    function automatic int clamp2(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // One clk_in cycle on the main DUT with model update and comparison.
    task automatic cycle();
        bit rdy_m;
        bit period_over;
        #1;
        rdy_m = !m_pend[cfg_ch];
        if (!rst) check("cfg_ready_model", {31'd0, cfg_ready}, {31'd0, rdy_m});
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_pos[i] = 0; m_per[i] = def_div[i]; m_stage[i] = def_div[i];
            end
            m_pend = '0; m_clk = '0; m_tick = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                period_over = (m_pos[i] == m_per[i] - 1);
                if (ch_en[i]) begin
                    m_clk[i]  = (m_pos[i] < m_per[i] / 2);
                    m_tick[i] = period_over;
                    m_pos[i]  = period_over ? 0 : m_pos[i] + 1;
                end else begin
                    m_clk[i] = 0; m_tick[i] = 0; m_pos[i] = 0;
                end
                if (m_pend[i] && (!ch_en[i] || period_over)) begin
                    m_per[i] = m_stage[i]; m_pend[i] = 0; m_pos[i] = 0;
                end
            end
            if (cfg_valid && rdy_m) begin
                m_stage[cfg_ch] = clamp2(int'(cfg_div));
                m_pend[cfg_ch]  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("outputs_model", {26'd0, clk_out, tick, cfg_pending}, {26'd0, m_clk, m_tick, m_pend});
    endtask

    task automatic do_reset(input bit [1:0] en);
        rst = 1; ch_en = en; cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
        cycle();
        cycle();
        check("reset_outputs", {26'd0, clk_out, tick, cfg_pending}, 32'd0);
        check("reset_ready", {31'd0, cfg_ready}, 32'd1);
        rst = 0;
    endtask

    typedef struct {
        bit [1:0]  en;
        bit        vld;
        bit [15:0] div;
        bit        rdy;
        bit [1:0]  clk;
        bit [1:0]  tck;
        bit [1:0]  pnd;
    } vec_t;
    vec_t tbl[$];

    task automatic add_vec(input bit [1:0] en, input bit vld, input int d, input bit rdy,
                           input bit [1:0] c, input bit [1:0] t, input bit [1:0] p);
        vec_t v;
        v.en = en; v.vld = vld; v.div = 16'(d); v.rdy = rdy; v.clk = c; v.tck = t; v.pnd = p;
        tbl.push_back(v);
    endtask

    initial begin
        int t0_first, t0_second, t1_first, high_cnt, waits;
        logic [11:0] seq_clk, seq_tick, seq_pend, exp_clk, exp_tick, exp_pend;

        b_rst = 1; b_en = 0; b_valid = 0; b_ch = 0; b_div = 0;

        // Divide-by-4, divide-by-5, then clamped divisors 1 and 0 (period 2) on ch0.
        add_vec(2'b00, 1, 4, 1, 2'b00, 2'b00, 2'b01);
        add_vec(2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b00, 2'b01, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b00, 2'b01, 2'b00);
        add_vec(2'b01, 1, 5, 1, 2'b01, 2'b00, 2'b01);
        add_vec(2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b01);
        add_vec(2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b01);
        add_vec(2'b01, 0, 0, 0, 2'b00, 2'b01, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b00, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b00, 2'b01, 2'b00);
        add_vec(2'b01, 1, 1, 1, 2'b01, 2'b00, 2'b01);
        add_vec(2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b01);
        add_vec(2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b01);
        add_vec(2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b01);
        add_vec(2'b01, 0, 0, 0, 2'b00, 2'b01, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b00, 2'b01, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b00, 2'b01, 2'b00);
        add_vec(2'b01, 1, 0, 1, 2'b01, 2'b00, 2'b01);
        add_vec(2'b01, 0, 0, 0, 2'b00, 2'b01, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b01, 2'b00, 2'b00);
        add_vec(2'b01, 0, 0, 1, 2'b00, 2'b01, 2'b00);

        do_reset(2'b00);
        for (int k = 0; k < tbl.size(); k++) begin
            ch_en = tbl[k].en; cfg_valid = tbl[k].vld; cfg_ch = 0; cfg_div = tbl[k].div;
            #1;
            check($sformatf("vec%0d_ready", k), {31'd0, cfg_ready}, {31'd0, tbl[k].rdy});
            cycle();
            check($sformatf("vec%0d_out", k), {26'd0, clk_out, tick, cfg_pending},
                  {26'd0, tbl[k].clk, tbl[k].tck, tbl[k].pnd});
        end

        // Mid-period reconfig: div 6 running, div 3 written while the phase is 2.
        do_reset(2'b00);
        cfg_valid = 1; cfg_ch = 0; cfg_div = 6; cycle();
        cfg_valid = 0; cycle();
        ch_en = 2'b01;
        seq_clk = '0; seq_tick = '0; seq_pend = '0;
        for (int e = 1; e <= 12; e++) begin
            cfg_valid = (e == 3); cfg_div = 3;
            cycle();
            seq_clk  = {seq_clk[10:0], clk_out[0]};
            seq_tick = {seq_tick[10:0], tick[0]};
            seq_pend = {seq_pend[10:0], cfg_pending[0]};
        end
        exp_clk = 12'b111000100100; exp_tick = 12'b000001001001; exp_pend = 12'b001110000000;
        check("reconfig_clk_seq", {20'd0, seq_clk}, {20'd0, exp_clk});
        check("reconfig_tick_seq", {20'd0, seq_tick}, {20'd0, exp_tick});
        check("reconfig_pend_seq", {20'd0, seq_pend}, {20'd0, exp_pend});

        // Back-pressure on ch0 while ch1 stays writable.
        do_reset(2'b00);
        cfg_valid = 1; cfg_ch = 0; cfg_div = 10; cycle();
        cfg_valid = 0; cycle();
        ch_en = 2'b01;
        cfg_valid = 1; cfg_ch = 0; cfg_div = 4; #1;
        check("bp_first_ready", {31'd0, cfg_ready}, 32'd1);
        cycle();
        cfg_div = 5; #1;
        check("bp_second_blocked", {31'd0, cfg_ready}, 32'd0);
        cycle();
        cfg_ch = 1; cfg_div = 7; #1;
        check("bp_ch1_ready", {31'd0, cfg_ready}, 32'd1);
        cycle();
        check("bp_both_pending", {30'd0, cfg_pending}, 32'd3);
        cfg_ch = 0; cfg_div = 5;
        waits = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (cfg_ready) break;
            waits++;
            cycle();
        end
        check("bp_wait_cycles", waits, 7);
        cycle();
        cfg_valid = 0;
        check("bp_second_accepted", {30'd0, cfg_pending}, 32'd1);

        // Randomized traffic against the model.
        do_reset(2'b00);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 49) == 0) ch_en = 2'($urandom_range(0, 3));
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 1'($urandom_range(0, 1));
            cfg_div   = 16'($urandom_range(0, 9));
            rst       = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 0; cfg_valid = 0;

        // Reset mid-period with a divisor pending.
        do_reset(2'b00);
        cfg_valid = 1; cfg_ch = 0; cfg_div = 6; cycle();
        cfg_valid = 0; cycle();
        ch_en = 2'b01; cycle();
        cfg_valid = 1; cfg_div = 3; cycle();
        cfg_valid = 0;
        check("pre_rst_state", {30'd0, clk_out[0], cfg_pending[0]}, 32'd3);
        rst = 1; cycle();
        check("rst_mid_outputs", {26'd0, clk_out, tick, cfg_pending}, 32'd0);
        ch_en = 2'b11; cycle();
        rst = 0;

        // Defaults after release: ch0 period 5000 (2500 high), ch1 period 50000.
        t0_first = 0; t0_second = 0; t1_first = 0; high_cnt = 0;
        for (int k = 1; k <= 50005; k++) begin
            cycle();
            if (tick[0]) begin
                if (t0_first == 0) t0_first = k;
                else if (t0_second == 0) t0_second = k;
            end
            if (tick[1] && t1_first == 0) t1_first = k;
            if (k <= 5000 && clk_out[0]) high_cnt++;
        end
        check("def_ch0_first_tick", t0_first, 5000);
        check("def_ch0_period", t0_second - t0_first, 5000);
        check("def_ch0_high", high_cnt, 2500);
        check("def_ch1_first_tick", t1_first, 50000);

        // Three-channel instance: clamped defaults and an out-of-range channel write.
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_rst = 0;
        check("b_reset_state", {23'd0, b_pend, b_clk, b_tick}, 32'd0);
        b_valid = 1; b_ch = 2'd3; b_div = 8'd5; #1;
        check("b_oob_ready", {31'd0, b_ready}, 32'd1);
        @(posedge clk); #1;
        b_valid = 0;
        check("b_oob_no_pending", {29'd0, b_pend}, 32'd0);
        b_en = 3'b111;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            check($sformatf("b_clk_%0d", k), {29'd0, b_clk},
                  {29'd0, (k % 7) < 3, (k % 2) == 0, (k % 2) == 0});
            check($sformatf("b_tick_%0d", k), {29'd0, b_tick},
                  {29'd0, (k % 7) == 6, (k % 2) == 1, (k % 2) == 1});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
